my_serial_adder: RTL and testbench
==================================

Name: my_serial_adder

Overview:
Multi-cycle, parametrised two's-complement adder/subtractor. Processes DIGIT bits per clock through a registered carry, trading latency for area. Successor to the combinational 16-bit adder, adding:
- arbitrary width
- a subtract mode
- carry-in
- carry-out and signed-overflow detection
- valid/ready handshakes on input and output
It sits between operand producers (ALU sequencer) and result consumers.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits added per clock; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode present.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: A+B+carry_in; 1: A-B computed as A+~B+1 (carry_in ignored).
- carry_in  input  1  carry into bit 0 when sub=0.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carry_out  output  1  carry out of the MSB (for sub: 1 means no borrow).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1; out_valid=0; sum=0; carry_out=0; overflow=0; digit counter=0.
- Reset mid-RUN or mid-DONE aborts the operation. The partial result is discarded and never presented.
- N = WIDTH/DIGIT.
- IDLE: in_ready=1. On an edge with in_valid=1, latch:
  - a
  - b, or ~b when sub=1
  - carry register = sub ? 1 : carry_in
  - count=0
  Then go to RUN.
- RUN: in_ready=0, out_valid=0. Each edge adds digit[count] of a, b and the carry register.
  - Write DIGIT sum bits to sum[count*DIGIT +: DIGIT].
  - Update the carry register.
  - On the last digit (count==N-1):
    - carry_out = carry out of the MSB.
    - overflow = carry into the MSB XOR carry out of the MSB.
    - Go to DONE.
- DONE: out_valid=1; sum, carry_out and overflow are stable. On an edge with out_ready=1, go to IDLE and set out_valid=0.
- Latency: out_valid rises exactly N edges after the accept edge (16/4 -> 4). With DIGIT=WIDTH, N=1.
- Throughput: one operation per N+2 cycles minimum (accept, N RUN, DONE). No overlap between operations.
- in_valid in RUN/DONE is ignored; operands are not captured. Producer must hold in_valid until in_ready.
- out_ready outside DONE has no effect.
- Operands changing after the accept edge do not affect the result.
- sum bits not yet written during RUN are don't-care. Consumers sample only when out_valid=1.
- Wrap-around: the result is truncated to WIDTH. Overflow is reported, never saturated.

Decomposition:
- Package my_adder_pkg:
  - state enum {IDLE, RUN, DONE}
  - mode constants MODE_ADD=0, MODE_SUB=1
  - helper function clog2-based counter width for N
- Sub-module my_adder_digit: combinational DIGIT-bit ripple adder.
  - Inputs: x, y, cin.
  - Outputs: s, cout, and c_msb_in (carry into the top bit, for overflow).
  - Instantiated once; the top level holds the FSM, counter and registers.

Test Plan:
- WIDTH=16, DIGIT=4; a=0x000F, b=0x000F, sub=0, carry_in=0 -> sum=0x001E, carry_out=0, overflow=0, out_valid exactly 4 edges after accept.
- a=0x4000, b=0x4000, add -> sum=0x8000, carry_out=0, overflow=1. Separately, a=0x8000, b=0x8000 -> sum=0x0000, carry_out=1, overflow=1.
- Subtract: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, carry_out=0, overflow=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, carry_out=1, overflow=1.
- Handshake: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0. A new in_valid with a=1, b=1 is ignored until out_ready=1; the following op gives sum=0x0002.
- Reset mid-RUN: assert reset 2 edges after accepting a=0xFFFF, b=0x0001 -> immediately out_valid=0, sum=0, in_ready=1. No result is ever presented.
- Parameter sweep: DIGIT=1, 16 and WIDTH=32, DIGIT=8. Use 0xFFFF..+carry_in=1 and random vectors vs reference model -> latency N, all flags match.

Source files
------------

// File: rtl/my_adder_pkg.sv
// Shared types and constants for the serial adder/subtractor.
package my_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Digit counter width; a single-digit configuration still needs one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/my_adder_digit.sv
// Combinational DIGIT-bit adder slice with carry-out and carry into its top bit.
module my_adder_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] w_full;

  assign w_full = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  assign s      = w_full[DIGIT-1:0];
  assign cout   = w_full[DIGIT];
  // Top sum bit is x ^ y ^ carry-in, so the carry into it falls out by XOR.
  assign c_msb_in = x[DIGIT-1] ^ y[DIGIT-1] ^ w_full[DIGIT-1];

endmodule

// File: rtl/my_serial_adder.sv
// Serial two's-complement adder/subtractor: DIGIT bits per clock through a registered carry.
// The result and flags are held in DONE until the consumer takes them.
module my_serial_adder
  import my_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // RUN   | adding one digit per edge, least significant first
  // DONE  | result and flags held, out_valid high

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;
  logic [WIDTH-1:0] w_sum_next;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_carry_out;
  logic             r_overflow;
  logic [DIGIT-1:0] w_s;
  logic             w_cout;
  logic             w_c_msb_in;
  logic             w_last;

  my_adder_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x       (r_a[DIGIT-1:0]),
    .y       (r_b[DIGIT-1:0]),
    .cin     (r_carry),
    .s       (w_s),
    .cout    (w_cout),
    .c_msb_in(w_c_msb_in)
  );

  // Operands shift down so the active digit always sits at bit 0; the sum fills from the top.
  generate
    if (N > 1) begin : g_shift
      assign w_a_next   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
      assign w_b_next   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
      assign w_sum_next = {w_s, r_sum[WIDTH-1:DIGIT]};
    end else begin : g_single
      assign w_a_next   = r_a;
      assign w_b_next   = r_b;
      assign w_sum_next = w_s;
    end
  endgenerate

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= (sub == MODE_SUB) ? ~b : b;
            r_carry <= (sub == MODE_SUB) ? 1'b1 : carry_in;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= w_a_next;
          r_b     <= w_b_next;
          r_sum   <= w_sum_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_carry_out <= w_cout;
            r_overflow  <= w_cout ^ w_c_msb_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_my_serial_adder.sv
// Self-checking bench: four configurations (16/4, 16/1, 16/16, 32/8) share one stimulus stream
// and are compared against a plain-arithmetic reference model.
module tb_my_serial_adder;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        sub_in;
  logic        cin_in;
  logic        out_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;

  logic        o_rdy [NI];
  logic        o_vld [NI];
  logic        o_co  [NI];
  logic        o_ov  [NI];
  logic [15:0] s0, s1, s2;
  logic [31:0] s3;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  my_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(o_rdy[0]),
    .a(a_in[15:0]), .b(b_in[15:0]), .sub(sub_in), .carry_in(cin_in),
    .out_valid(o_vld[0]), .out_ready(out_ready), .sum(s0),
    .carry_out(o_co[0]), .overflow(o_ov[0]));

  my_serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(o_rdy[1]),
    .a(a_in[15:0]), .b(b_in[15:0]), .sub(sub_in), .carry_in(cin_in),
    .out_valid(o_vld[1]), .out_ready(out_ready), .sum(s1),
    .carry_out(o_co[1]), .overflow(o_ov[1]));

  my_serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(o_rdy[2]),
    .a(a_in[15:0]), .b(b_in[15:0]), .sub(sub_in), .carry_in(cin_in),
    .out_valid(o_vld[2]), .out_ready(out_ready), .sum(s2),
    .carry_out(o_co[2]), .overflow(o_ov[2]));

  my_serial_adder #(.WIDTH(32), .DIGIT(8)) u_w32 (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(o_rdy[3]),
    .a(a_in), .b(b_in), .sub(sub_in), .carry_in(cin_in),
    .out_valid(o_vld[3]), .out_ready(out_ready), .sum(s3),
    .carry_out(o_co[3]), .overflow(o_ov[3]));

  function automatic int width_of(input int i);
    return (i == 3) ? 32 : 16;
  endfunction

  function automatic int ndig_of(input int i);
    case (i)
      0:       return 4;
      1:       return 16;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] get_sum(input int i);
    case (i)
      0:       return {16'h0, s0};
      1:       return {16'h0, s1};
      2:       return {16'h0, s2};
      default: return s3;
    endcase
  endfunction

  // Reference: {overflow, carry_out, sum} from whole-word arithmetic and sign rules.
  function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic s, input logic c);
    logic [63:0] mask, xa, yb, full;
    logic        co, ov, sa, sb, sr;
    mask = (64'd1 << w) - 64'd1;
    xa   = {32'h0, x} & mask;
    yb   = (s ? ~{32'h0, y} : {32'h0, y}) & mask;
    full = xa + yb + (s ? 64'd1 : {63'h0, c});
    co   = full[w];
    sa   = xa[w-1];
    sb   = yb[w-1];
    sr   = full[w-1];
    ov   = (sa == sb) && (sr != sa);
    return {ov, co, full[31:0] & mask[31:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] x, input logic [31:0] y,
                              input logic s, input logic c);
    logic [33:0] e;
    for (int i = 0; i < NI; i++) begin
      e = model(width_of(i), x, y, s, c);
      check($sformatf("%s/u%0d sum", tag, i), get_sum(i), e[31:0]);
      check($sformatf("%s/u%0d carry_out", tag, i), {31'h0, o_co[i]}, {31'h0, e[32]});
      check($sformatf("%s/u%0d overflow", tag, i), {31'h0, o_ov[i]}, {31'h0, e[33]});
    end
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s/u%0d out_valid", tag, i), {31'h0, o_vld[i]}, 32'h0);
      check($sformatf("%s/u%0d in_ready", tag, i), {31'h0, o_rdy[i]}, 32'h1);
    end
  endtask

  // Called one step after an edge; accepts on the next edge and completes the handshake.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic s, input logic c);
    int lat [NI];
    bit all_seen;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s/u%0d ready_before", tag, i), {31'h0, o_rdy[i]}, 32'h1);
      lat[i] = -1;
    end
    a_in = x; b_in = y; sub_in = s; cin_in = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_in = $urandom; b_in = $urandom; sub_in = ~s; cin_in = ~c;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      all_seen = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (lat[i] < 0 && o_vld[i]) lat[i] = cyc;
        if (lat[i] < 0) all_seen = 1'b0;
      end
      if (all_seen) break;
    end
    for (int i = 0; i < NI; i++)
      check($sformatf("%s/u%0d latency", tag, i), 32'(lat[i]), 32'(ndig_of(i)));
    check_result(tag, x, y, s, c);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_idle({tag, "_release"});
  endtask

  initial begin
    logic [33:0] e;
    bit          seen;
    logic [31:0] ra, rb;
    logic        rs, rc;

    rst = 1'b1; in_valid = 1'b0; sub_in = 1'b0; cin_in = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("reset");
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset/u%0d sum", i), get_sum(i), 32'h0);
      check($sformatf("reset/u%0d carry_out", i), {31'h0, o_co[i]}, 32'h0);
      check($sformatf("reset/u%0d overflow", i), {31'h0, o_ov[i]}, 32'h0);
    end

    @(posedge clk); #1;
    run_op("add_f_f",     32'h0000_000F, 32'h0000_000F, 1'b0, 1'b0);
    run_op("add_4k_4k",   32'h0000_4000, 32'h0000_4000, 1'b0, 1'b0);
    run_op("add_8k_8k",   32'h0000_8000, 32'h0000_8000, 1'b0, 1'b0);
    run_op("sub_5_7",     32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
    run_op("sub_8k_1",    32'h0000_8000, 32'h0000_0001, 1'b1, 1'b0);
    run_op("sub_cin_ign", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    run_op("ones_cin",    32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    run_op("ones_ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_op("max_cin",     32'h7FFF_7FFF, 32'h0000_0000, 1'b0, 1'b1);

    // Hold the result for five cycles while a competing request waits.
    a_in = 32'h0000_1234; b_in = 32'h0000_1111; sub_in = 1'b0; cin_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    a_in = 32'h1; b_in = 32'h1; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        check($sformatf("hold/u%0d out_valid", i), {31'h0, o_vld[i]}, 32'h1);
        check($sformatf("hold/u%0d in_ready", i), {31'h0, o_rdy[i]}, 32'h0);
      end
      check_result("hold", 32'h0000_1234, 32'h0000_1111, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_idle("hold_release");
    run_op("after_hold", 32'h1, 32'h1, 1'b0, 1'b0);

    // Reset two edges after accept: every configuration is in RUN or DONE.
    a_in = 32'h0000_FFFF; b_in = 32'h0000_0001; sub_in = 1'b0; cin_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_idle("abort");
    for (int i = 0; i < NI; i++)
      check($sformatf("abort/u%0d sum", i), get_sum(i), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) if (o_vld[i]) seen = 1'b1;
    end
    check("abort no_result", {31'h0, seen}, 32'h0);

    for (int k = 0; k < 12; k++) begin
      ra = $urandom; rb = $urandom;
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", k), ra, rb, rs, rc);
    end

    e = model(16, 32'h0000_8000, 32'h0000_0001, 1'b1, 1'b0);
    check("model_sanity sub_8k_1", {e[33], e[32], 14'h0, e[15:0]}, {2'b11, 14'h0, 16'h7FFF});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
